// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int unsigned N_DEF    = 4;
   localparam int unsigned DW_DEF   = 16;
   localparam int unsigned KW_DEF   = 8;
   localparam int unsigned HOP_DEF  = 2;
   localparam int unsigned PIPE_DEF = 3;

   // Read latency + return register, feed skew, array propagation, PE pipeline.
   function automatic int unsigned drain_cyc(input int unsigned n,
                                             input int unsigned hop,
                                             input int unsigned pipe);
      return 2 + hop * (n - 1) + hop * (n - 1) + pipe;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Job handshake, operand-buffer read ports and array edge feeds of the sequencer.
interface systolic_seq_ctrl_if
   import systolic_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned KW = KW_DEF
) ();

   logic            start;
   logic [KW-1:0]   k_len;
   logic            busy;
   logic            done;
   logic            a_rd_en;
   logic [KW-1:0]   a_rd_addr;
   logic [N*DW-1:0] a_rd_data;
   logic            b_rd_en;
   logic [KW-1:0]   b_rd_addr;
   logic [N*DW-1:0] b_rd_data;
   logic [N*DW-1:0] a_feed;
   logic [N*DW-1:0] b_feed;
   logic [N-1:0]    valid_feed;

   modport master (
      output start, k_len, a_rd_data, b_rd_data,
      input  busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             a_feed, b_feed, valid_feed
   );

   modport slave (
      input  start, k_len, a_rd_data, b_rd_data,
      output busy, done, a_rd_en, a_rd_addr, b_rd_en, b_rd_addr,
             a_feed, b_feed, valid_feed
   );

endinterface

// File: rtl/systolic_seq_ctrl_skew_line.sv
// skew_line: W-bit shift register of DEPTH stages with async clear; DEPTH=0 is a wire.
module skew_line #(
   parameter int unsigned W     = 1,
   parameter int unsigned DEPTH = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst_n;
         assign q = d;
      end else begin : g_shift
         logic [DEPTH-1:0][W-1:0] sr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sr <= '0;
            end else begin
               sr[0] <= d;
               for (int s = 1; s < int'(DEPTH); s++) begin
                  sr[s] <= sr[s-1];
               end
            end
         end

         assign q = sr[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N systolic array: fetches K operand vectors,
// feeds them skewed into the array edges and pulses done once the array has drained.
module systolic_seq_ctrl
   import systolic_pkg::*;
#(
   parameter int unsigned N    = N_DEF,
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned KW   = KW_DEF,
   parameter int unsigned HOP  = HOP_DEF,
   parameter int unsigned PIPE = PIPE_DEF
) (
   input logic                 clk,
   input logic                 rst_n,
   systolic_seq_ctrl_if.slave  bus
);

   localparam int unsigned DRAIN_CYC = drain_cyc(N, HOP, PIPE);
   localparam int unsigned CW        = max_u(KW, $clog2(DRAIN_CYC + 1));

   state_t          state;
   logic [KW-1:0]   k_lat;
   logic [KW-1:0]   k_addr;
   logic [CW-1:0]   drain_cnt;
   logic            rd_en;
   logic            busy;
   logic            done;
   logic            rd_pend;
   logic            ret_valid;
   logic [N*DW-1:0] a_ret;
   logic [N*DW-1:0] b_ret;

   assign bus.a_rd_en   = rd_en;
   assign bus.b_rd_en   = rd_en;
   assign bus.a_rd_addr = k_addr;
   assign bus.b_rd_addr = k_addr;
   assign bus.busy      = busy;
   assign bus.done      = done;

   // Job FSM; address counter stops at K-1 so K = 2**KW-1 never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         k_lat     <= '0;
         k_addr    <= '0;
         drain_cnt <= '0;
         rd_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  k_lat  <= bus.k_len;
                  k_addr <= '0;
                  busy   <= 1'b1;
                  if (bus.k_len == '0) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_FETCH;
                     rd_en <= 1'b1;
                  end
               end
            end
            ST_FETCH: begin
               if (k_addr == k_lat - KW'(1)) begin
                  state     <= ST_DRAIN;
                  rd_en     <= 1'b0;
                  k_addr    <= '0;
                  drain_cnt <= '0;
               end else begin
                  k_addr <= k_addr + KW'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == CW'(DRAIN_CYC - 1)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + CW'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Read-return register; lanes are zeroed outside real beats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend   <= 1'b0;
         ret_valid <= 1'b0;
         a_ret     <= '0;
         b_ret     <= '0;
      end else begin
         rd_pend   <= rd_en;
         ret_valid <= rd_pend;
         a_ret     <= rd_pend ? bus.a_rd_data : '0;
         b_ret     <= rd_pend ? bus.b_rd_data : '0;
      end
   end

   for (genvar i = 0; i < int'(N); i++) begin : g_lane
      skew_line #(.W(DW), .DEPTH(HOP * i)) u_skew_a (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (a_ret[i*DW +: DW]),
         .q     (bus.a_feed[i*DW +: DW])
      );
      skew_line #(.W(DW), .DEPTH(HOP * i)) u_skew_b (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (b_ret[i*DW +: DW]),
         .q     (bus.b_feed[i*DW +: DW])
      );
      skew_line #(.W(1), .DEPTH(HOP * i)) u_skew_v (
         .clk   (clk),
         .rst_n (rst_n),
         .d     (ret_valid),
         .q     (bus.valid_feed[i])
      );
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench for systolic_seq_ctrl: operand-buffer model, feed monitor and matrix reference.
module tb_systolic_seq_ctrl;
   import systolic_pkg::*;

   localparam int unsigned N     = N_DEF;
   localparam int unsigned DW    = DW_DEF;
   localparam int unsigned KW    = KW_DEF;
   localparam int unsigned HOP   = HOP_DEF;
   localparam int unsigned PIPE  = PIPE_DEF;
   localparam int          DRAIN = 17;
   localparam int unsigned LW    = N * DW;
   localparam int unsigned AW    = 32;
   localparam int unsigned CWID  = N * N * AW;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   systolic_seq_ctrl_if #(.N(N), .DW(DW), .KW(KW)) bus ();

   systolic_seq_ctrl #(.N(N), .DW(DW), .KW(KW), .HOP(HOP), .PIPE(PIPE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [LW-1:0] amem [256];
   logic [LW-1:0] bmem [256];

   int            busy_n, done_n, rd_n, rd_first, rd_bad, zero_bad;
   logic [KW-1:0] last_addr;
   int            first_v [N];
   int            last_v  [N];
   int            nv      [N];
   logic [DW-1:0] aq [N][$];
   logic [DW-1:0] bq [N][$];

   always @(posedge clk) cyc <= cyc + 1;

   // Operand buffers: 1-cycle read latency, junk when not read.
   always @(posedge clk) begin
      bus.a_rd_data <= bus.a_rd_en ? amem[bus.a_rd_addr] : LW'({$urandom, $urandom});
      bus.b_rd_data <= bus.b_rd_en ? bmem[bus.b_rd_addr] : LW'({$urandom, $urandom});
   end

   // Monitor: records reads, done/busy activity and per-lane beats.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.busy) busy_n++;
         if (bus.done) done_n++;
         if (bus.a_rd_en) begin
            if (bus.a_rd_addr !== KW'(rd_n) || !bus.b_rd_en || bus.b_rd_addr !== bus.a_rd_addr)
               rd_bad++;
            if (rd_n == 0) rd_first = cyc;
            last_addr = bus.a_rd_addr;
            rd_n++;
         end else if (bus.b_rd_en) begin
            rd_bad++;
         end
         for (int i = 0; i < int'(N); i++) begin
            if (bus.valid_feed[i]) begin
               aq[i].push_back(bus.a_feed[i*DW +: DW]);
               bq[i].push_back(bus.b_feed[i*DW +: DW]);
               if (nv[i] == 0) first_v[i] = cyc;
               last_v[i] = cyc;
               nv[i]++;
            end else if (bus.a_feed[i*DW +: DW] != '0 || bus.b_feed[i*DW +: DW] != '0) begin
               zero_bad++;
            end
         end
      end
   end

   task automatic clear_mon();
      busy_n = 0; done_n = 0; rd_n = 0; rd_first = -1; rd_bad = 0; zero_bad = 0;
      last_addr = '0;
      for (int i = 0; i < int'(N); i++) begin
         first_v[i] = -1; last_v[i] = -1; nv[i] = 0;
         aq[i].delete(); bq[i].delete();
      end
   endtask

   task automatic fill_random();
      for (int k = 0; k < 256; k++) begin
         amem[k] = LW'({$urandom, $urandom});
         bmem[k] = LW'({$urandom, $urandom});
      end
   endtask

   // C[i][j] = sum_k A(row i, k) * B(k, col j), straight from the buffer contents.
   function automatic logic [CWID-1:0] ref_c(input int k_len);
      logic [CWID-1:0] c;
      logic [AW-1:0]   acc;
      c = '0;
      for (int i = 0; i < int'(N); i++)
         for (int j = 0; j < int'(N); j++) begin
            acc = '0;
            for (int k = 0; k < k_len; k++)
               acc += AW'(amem[k][i*DW +: DW]) * AW'(bmem[k][j*DW +: DW]);
            c[(i*N+j)*AW +: AW] = acc;
         end
      return c;
   endfunction

   // Matrix the array would accumulate from the beats seen on its edges.
   function automatic logic [CWID-1:0] obs_c();
      logic [CWID-1:0] c;
      logic [AW-1:0]   acc;
      c = '0;
      for (int i = 0; i < int'(N); i++)
         for (int j = 0; j < int'(N); j++) begin
            acc = '0;
            for (int k = 0; k < int'(aq[i].size()) && k < int'(bq[j].size()); k++)
               acc += AW'(aq[i][k]) * AW'(bq[j][k]);
            c[(i*N+j)*AW +: AW] = acc;
         end
      return c;
   endfunction

   // Lanes whose beat window differs from t0+2+HOP*i .. +K-1.
   function automatic int lanes_bad(input int t0, input int k_len);
      int bad;
      int f;
      bad = 0;
      for (int i = 0; i < int'(N); i++) begin
         f = t0 + 2 + int'(HOP) * i;
         if (k_len == 0) begin
            if (nv[i] != 0) bad++;
         end else if (first_v[i] != f || last_v[i] != f + k_len - 1 || nv[i] != k_len) begin
            bad++;
         end
      end
      return bad;
   endfunction

   task automatic start_job(input int k_len, output int t0);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.k_len = KW'(k_len);
      @(posedge clk); #1;
      t0 = cyc;
      bus.start = 1'b0;
      bus.k_len = KW'($urandom);
   endtask

   task automatic wait_done(input int bound, output bit ok, output int dcyc);
      ok = 1'b0;
      dcyc = -1;
      for (int c = 0; c < bound && !ok; c++) begin
         @(negedge clk);
         if (bus.done) begin
            ok = 1'b1;
            dcyc = cyc;
         end
      end
      #1;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.a_rd_addr, bus.b_rd_addr,
           bus.a_feed, bus.b_feed, bus.valid_feed} !== '0) begin
         failures++;
         $display("FAIL reset_outputs actual busy=%b done=%b rd=%b valid=%b required all zero",
                  bus.busy, bus.done, bus.a_rd_en, bus.valid_feed);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      clear_mon();
      settle(3);
      checks++;
      if (busy_n !== 0 || done_n !== 0 || rd_n !== 0) begin
         failures++;
         $display("FAIL reset_idle actual busy=%0d done=%0d reads=%0d required 0/0/0", busy_n, done_n, rd_n);
      end
   endtask

   task automatic test_identity();
      int t0, dcyc;
      bit ok;
      logic [CWID-1:0] ident, got;
      ident = '0;
      for (int k = 0; k < 256; k++) begin
         amem[k] = '0;
         bmem[k] = '0;
         if (k < int'(N)) begin
            amem[k][k*DW +: DW] = DW'(1);
            bmem[k][k*DW +: DW] = DW'(1);
            ident[(k*N+k)*AW +: AW] = AW'(1);
         end
      end
      clear_mon();
      start_job(4, t0);
      wait_done(60, ok, dcyc);
      settle(3);
      got = obs_c();
      checks++;
      if (!ok || dcyc !== t0 + 4 + DRAIN) begin
         failures++;
         $display("FAIL id_done_cycle actual=%0d required=%0d", dcyc, t0 + 4 + DRAIN);
      end
      checks++;
      if (rd_n !== 4 || rd_first !== t0 || rd_bad !== 0) begin
         failures++;
         $display("FAIL id_reads actual n=%0d first=%0d bad=%0d required n=4 first=%0d bad=0", rd_n, rd_first, rd_bad, t0);
      end
      checks++;
      if (first_v[0] !== t0 + 2 || last_v[0] !== t0 + 5 || first_v[3] !== t0 + 8 || last_v[3] !== t0 + 11) begin
         failures++;
         $display("FAIL id_valid_window actual lane0=%0d..%0d lane3=%0d..%0d required %0d..%0d / %0d..%0d",
                  first_v[0], last_v[0], first_v[3], last_v[3], t0 + 2, t0 + 5, t0 + 8, t0 + 11);
      end
      checks++;
      if (lanes_bad(t0, 4) !== 0 || zero_bad !== 0) begin
         failures++;
         $display("FAIL id_lanes actual bad_lanes=%0d nonzero_idle=%0d required 0/0", lanes_bad(t0, 4), zero_bad);
      end
      checks++;
      if (got !== ident) begin
         failures++;
         $display("FAIL id_matrix actual=%h required=%h", got, ident);
      end
      checks++;
      if (busy_n !== 4 + DRAIN + 1 || done_n !== 1) begin
         failures++;
         $display("FAIL id_busy actual busy=%0d done=%0d required busy=%0d done=1", busy_n, done_n, 4 + DRAIN + 1);
      end
   endtask

   task automatic test_zero_len();
      int t0, dcyc;
      bit ok;
      clear_mon();
      start_job(0, t0);
      wait_done(5, ok, dcyc);
      settle(5);
      checks++;
      if (!ok || dcyc !== t0) begin
         failures++;
         $display("FAIL zero_done_cycle actual=%0d required=%0d", dcyc, t0);
      end
      checks++;
      if (rd_n !== 0 || rd_bad !== 0 || lanes_bad(t0, 0) !== 0) begin
         failures++;
         $display("FAIL zero_activity actual reads=%0d bad=%0d lanes=%0d required 0/0/0", rd_n, rd_bad, lanes_bad(t0, 0));
      end
      checks++;
      if (busy_n !== 1 || done_n !== 1) begin
         failures++;
         $display("FAIL zero_busy actual busy=%0d done=%0d required 1/1", busy_n, done_n);
      end
   endtask

   task automatic test_start_while_busy();
      int t0, dcyc;
      bit ok;
      fill_random();
      clear_mon();
      start_job(4, t0);
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.k_len = KW'($urandom_range(1, 9));
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done(60, ok, dcyc);
      settle(25);
      checks++;
      if (!ok || dcyc !== t0 + 4 + DRAIN) begin
         failures++;
         $display("FAIL busy_done_cycle actual=%0d required=%0d", dcyc, t0 + 4 + DRAIN);
      end
      checks++;
      if (done_n !== 1 || busy_n !== 4 + DRAIN + 1 || rd_n !== 4) begin
         failures++;
         $display("FAIL busy_ignored actual done=%0d busy=%0d reads=%0d required 1/%0d/4", done_n, busy_n, rd_n, 4 + DRAIN + 1);
      end
      checks++;
      if (obs_c() !== ref_c(4)) begin
         failures++;
         $display("FAIL busy_matrix actual=%h required=%h", obs_c(), ref_c(4));
      end
   endtask

   task automatic test_back_to_back();
      int t0a, t0b, d1, d2, last0;
      bit ok1, ok2;
      fill_random();
      clear_mon();
      start_job(3, t0a);
      wait_done(60, ok1, d1);
      checks++;
      if (!ok1 || d1 !== t0a + 3 + DRAIN || obs_c() !== ref_c(3) || lanes_bad(t0a, 3) !== 0) begin
         failures++;
         $display("FAIL b2b_job1 actual done=%0d lanes=%0d required done=%0d lanes=0 matrix match", d1, lanes_bad(t0a, 3), t0a + 3 + DRAIN);
      end
      last0 = last_v[0];
      fill_random();
      clear_mon();
      start_job(5, t0b);
      wait_done(60, ok2, d2);
      settle(3);
      checks++;
      if (t0b !== d1 + 2) begin
         failures++;
         $display("FAIL b2b_accept actual t0=%0d required=%0d", t0b, d1 + 2);
      end
      checks++;
      if (!ok2 || d2 !== t0b + 5 + DRAIN) begin
         failures++;
         $display("FAIL b2b_done2 actual=%0d required=%0d", d2, t0b + 5 + DRAIN);
      end
      checks++;
      if (obs_c() !== ref_c(5) || lanes_bad(t0b, 5) !== 0 || rd_bad !== 0) begin
         failures++;
         $display("FAIL b2b_job2 actual=%h required=%h", obs_c(), ref_c(5));
      end
      checks++;
      if (first_v[0] - last0 - 1 < DRAIN) begin
         failures++;
         $display("FAIL b2b_gap actual=%0d required>=%0d", first_v[0] - last0 - 1, DRAIN);
      end
   endtask

   task automatic test_mid_reset();
      int t0, dcyc;
      bit ok;
      fill_random();
      clear_mon();
      start_job(8, t0);
      repeat (6) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.busy, bus.done, bus.a_rd_en, bus.b_rd_en, bus.a_rd_addr, bus.b_rd_addr,
           bus.a_feed, bus.b_feed, bus.valid_feed} !== '0) begin
         failures++;
         $display("FAIL mreset_outputs actual busy=%b rd=%b addr=%0d valid=%b required all zero",
                  bus.busy, bus.a_rd_en, bus.a_rd_addr, bus.valid_feed);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      settle(30);
      checks++;
      if (done_n !== 0) begin
         failures++;
         $display("FAIL mreset_no_done actual=%0d required=0", done_n);
      end
      fill_random();
      clear_mon();
      start_job(2, t0);
      wait_done(60, ok, dcyc);
      settle(3);
      checks++;
      if (!ok || dcyc !== t0 + 2 + DRAIN || obs_c() !== ref_c(2) || lanes_bad(t0, 2) !== 0) begin
         failures++;
         $display("FAIL mreset_fresh_job actual done=%0d lanes=%0d required done=%0d lanes=0 matrix match",
                  dcyc, lanes_bad(t0, 2), t0 + 2 + DRAIN);
      end
   endtask

   task automatic test_max_len();
      int t0, dcyc;
      bit ok;
      fill_random();
      clear_mon();
      start_job(255, t0);
      wait_done(400, ok, dcyc);
      settle(3);
      checks++;
      if (!ok || dcyc !== t0 + 255 + DRAIN) begin
         failures++;
         $display("FAIL max_done_cycle actual=%0d required=%0d", dcyc, t0 + 255 + DRAIN);
      end
      checks++;
      if (rd_n !== 255 || last_addr !== KW'(254) || rd_bad !== 0) begin
         failures++;
         $display("FAIL max_reads actual n=%0d last=%0d bad=%0d required 255/254/0", rd_n, last_addr, rd_bad);
      end
      checks++;
      if (obs_c() !== ref_c(255) || lanes_bad(t0, 255) !== 0 || zero_bad !== 0) begin
         failures++;
         $display("FAIL max_matrix actual=%h required=%h", obs_c(), ref_c(255));
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.k_len = '0;
      clear_mon();
      test_reset();
      test_identity();
      test_zero_len();
      test_start_while_busy();
      test_back_to_back();
      test_mid_reset();
      test_max_len();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
